// File: rtl/brent_kung_adder.sv
// ============================================================================
//  Module   : brent_kung_adder
//  Function : Registered 16-bit Brent-Kung prefix adder, sum = a + b + cin.
//  Option   : BRENT_KUNG_PIPE_EN adds a register after the up-sweep (latency 2).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module brent_kung_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [16:0] sum,
  output logic        out_valid
);

  logic [15:0]      w_g;
  logic [15:0]      w_p;
  logic [4:0][15:0] w_gu;   // up-sweep group generate, index = level
  logic [4:0][15:0] w_pu;
  logic [15:0]      w_gm;   // up-sweep result feeding the down-sweep
  logic [15:0]      w_pm;
  logic [3:0][15:0] w_gd;   // down-sweep, [3] holds every G[i:0]
  logic [15:0]      w_p_s;
  logic             w_cin_s;
  logic             w_valid_s;
  logic [16:0]      w_c;
  logic [16:0]      sum_d;
  logic [16:0]      sum_q;
  logic             out_valid_q;

  assign w_g = a & b;
  assign w_p = a ^ b;

  assign w_gu[0] = {w_g[15:1], w_g[0] | (w_p[0] & cin)};
  assign w_pu[0] = w_p;

  genvar lv, i, d;
  generate
    for (lv = 1; lv <= 4; lv++) begin : g_up_level
      for (i = 0; i < 16; i++) begin : g_up_bit
        if (((i + 1) % (1 << lv)) == 0) begin : g_node
          assign w_gu[lv][i] = w_gu[lv-1][i] |
                               (w_pu[lv-1][i] & w_gu[lv-1][i - (1 << (lv-1))]);
          assign w_pu[lv][i] = w_pu[lv-1][i] & w_pu[lv-1][i - (1 << (lv-1))];
        end else begin : g_pass
          assign w_gu[lv][i] = w_gu[lv-1][i];
          assign w_pu[lv][i] = w_pu[lv-1][i];
        end
      end
    end
  endgenerate

`ifdef BRENT_KUNG_PIPE_EN
  // cin is carried along with p because sum[0] needs the raw carry-in.
  logic [15:0] mid_g_q;
  logic [15:0] mid_p_q;
  logic [15:0] p_q;
  logic        cin_q;
  logic        valid1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mid_g_q  <= 16'h0;
      mid_p_q  <= 16'h0;
      p_q      <= 16'h0;
      cin_q    <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      mid_g_q  <= w_gu[4];
      mid_p_q  <= w_pu[4];
      p_q      <= w_p;
      cin_q    <= cin;
      valid1_q <= in_valid;
    end
  end

  assign w_gm      = mid_g_q;
  assign w_pm      = mid_p_q;
  assign w_p_s     = p_q;
  assign w_cin_s   = cin_q;
  assign w_valid_s = valid1_q;
`else
  assign w_gm      = w_gu[4];
  assign w_pm      = w_pu[4];
  assign w_p_s     = w_p;
  assign w_cin_s   = cin;
  assign w_valid_s = in_valid;
`endif

  assign w_gd[0] = w_gm;

  // Each down-sweep node is written once, so its span still matches w_pm[i].
  generate
    for (d = 1; d <= 3; d++) begin : g_dn_level
      localparam int K = 4 - d;
      for (i = 0; i < 16; i++) begin : g_dn_bit
        if ((i >= (1 << K)) && (((i + 1 - (1 << (K-1))) % (1 << K)) == 0)) begin : g_node
          assign w_gd[d][i] = w_gd[d-1][i] |
                              (w_pm[i] & w_gd[d-1][i - (1 << (K-1))]);
        end else begin : g_pass
          assign w_gd[d][i] = w_gd[d-1][i];
        end
      end
    end
  endgenerate

  logic w_unused_p;
  assign w_unused_p = ^w_pm;

  assign w_c   = {w_gd[3], w_cin_s};
  assign sum_d = {w_c[16], w_p_s ^ w_c[15:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= 17'h0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      out_valid_q <= w_valid_s;
    end
  end

  assign sum       = sum_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_brent_kung_adder.sv
// ============================================================================
//  Module   : tb_brent_kung_adder
//  Function : Directed and random self-checking bench for brent_kung_adder.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_brent_kung_adder;

`ifdef BRENT_KUNG_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [16:0] sum;
  logic        out_valid;

  int n_vec = 0;
  int n_err = 0;

  // Reference pipeline: valid and a+b+cin per stage, cleared by rst.
  logic        mv [2];
  logic [16:0] ms [2];

  always #5 clk = ~clk;

  brent_kung_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .out_valid (out_valid)
  );

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        mv[s] = 1'b0;
        ms[s] = 17'h0;
      end
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        mv[s] = mv[s-1];
        ms[s] = ms[s-1];
      end
      mv[0] = in_valid;
      ms[0] = 17'(a) + 17'(b) + 17'(cin);
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] aa, input logic [15:0] bb,
                       input logic cc);
    in_valid = v;
    a        = aa;
    b        = bb;
    cin      = cc;
  endtask

  // Present one operand set, then idle until its result is due.
  task automatic issue(input logic [15:0] aa, input logic [15:0] bb, input logic cc);
    drive(1'b1, aa, bb, cc);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    for (int k = 1; k < LAT; k++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0 || sum !== 17'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: out_valid=%b sum=%h, want 0/00000", k, out_valid, sum);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      drive(1'b0, 16'h0, 16'h0, 1'b0);
      n_vec++;
      if (out_valid !== (k == LAT)) begin
        n_err++;
        $display("FAIL reset_release cyc%0d: out_valid=%b want %b", k, out_valid, (k == LAT));
      end
    end
    n_vec++;
    if (sum !== 17'h10001) begin
      n_err++;
      $display("FAIL reset_first_sum: sum=%h want 10001", sum);
    end
  endtask

  task automatic test_basic();
    issue(16'd902, 16'd3932, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || sum !== 17'd4834) begin
      n_err++;
      $display("FAIL basic: out_valid=%b sum=%0d want 1/4834", out_valid, sum);
    end
    issue(16'h1234, 16'h4321, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || sum !== 17'h05556) begin
      n_err++;
      $display("FAIL basic_cin: out_valid=%b sum=%h want 1/05556", out_valid, sum);
    end
  endtask

  task automatic test_carry_chain();
    issue(16'hFFFF, 16'h0000, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || sum !== 17'h10000) begin
      n_err++;
      $display("FAIL chain_ffff_0_1: out_valid=%b sum=%h want 1/10000", out_valid, sum);
    end
    issue(16'hFFFF, 16'hFFFF, 1'b1);
    n_vec++;
    if (out_valid !== 1'b1 || sum !== 17'h1FFFF) begin
      n_err++;
      $display("FAIL chain_ffff_ffff_1: out_valid=%b sum=%h want 1/1FFFF", out_valid, sum);
    end
    issue(16'h0000, 16'h0000, 1'b0);
    n_vec++;
    if (out_valid !== 1'b1 || sum !== 17'h00000) begin
      n_err++;
      $display("FAIL chain_zero: out_valid=%b sum=%h want 1/00000", out_valid, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [16:0] ve [3];
    va = '{16'd1, 16'h8000, 16'h00FF};
    vb = '{16'd1, 16'h8000, 16'h0001};
    vc = '{1'b0, 1'b0, 1'b1};
    ve = '{17'd2, 17'h10000, 17'h00101};
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c < 3) drive(1'b1, va[c], vb[c], vc[c]);
      else       drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      if (c >= LAT - 1) begin
        int k = c - (LAT - 1);
        n_vec++;
        if (k < 3) begin
          if (out_valid !== 1'b1 || sum !== ve[k]) begin
            n_err++;
            $display("FAIL b2b_%0d: out_valid=%b sum=%h want 1/%h", k, out_valid, sum, ve[k]);
          end
        end else if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_bubble: out_valid=%b want 0", out_valid);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 100 + LAT; i++) begin
      rst = (i == 50);
      if (i < 100)
        drive(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 19999)),
              16'($urandom_range(0, 19999)), 1'($urandom_range(0, 1)));
      else
        drive(1'b0, 16'h0, 16'h0, 1'b0);
      tick();
      n_vec++;
      if (out_valid !== mv[LAT-1]) begin
        n_err++;
        $display("FAIL rand_valid i=%0d: out_valid=%b want %b", i, out_valid, mv[LAT-1]);
      end else if (mv[LAT-1] && sum !== ms[LAT-1]) begin
        n_err++;
        $display("FAIL rand_sum i=%0d: sum=%h want %h", i, sum, ms[LAT-1]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    for (int s = 0; s < 2; s++) begin
      mv[s] = 1'b0;
      ms[s] = 17'h0;
    end
    #1;
    test_reset();
    test_basic();
    test_carry_chain();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/brent_kung_adder.md
# brent_kung_adder

Registered 16-bit Brent-Kung parallel-prefix adder with carry-in and a 17-bit result including carry-out. It is the arithmetic datapath block of the adder subsystem and is used wherever a low-fanout, log-depth carry network is needed. It also serves as the golden structure for comparing prefix-adder topologies against the behavioural `+` operator.

## Interface
Parameters: none; the width is fixed at 16 bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  qualifies a, b, cin this cycle
- a  input  16  operand A, unsigned
- b  input  16  operand B, unsigned
- cin  input  1  carry-in
- sum  output  17  registered result; sum[16] = carry-out
- out_valid  output  1  sum holds a result for a qualified input

## Operation
- Result: sum = a + b + cin, exact unsigned 17-bit; no overflow or wrap is possible.
- The carry path must be built as an explicit Brent-Kung prefix network.
  - The `+` operator is forbidden in the carry and sum logic.
  - Verification compares against `+`.
- Pre-processing:
  - g[i] = a[i] & b[i] and p[i] = a[i] ^ b[i] for i = 0..15.
  - cin is folded into bit 0: G0 = g[0] | (p[0] & cin).
- Prefix operator (G,P)∘(G',P') = (G | P&G', P&P'), where the unprimed pair is the more significant group.
- Up-sweep, levels k = 1..4: nodes at i = m·2^k − 1 combine with i − 2^(k−1).
  - Produces G[1:0], G[3:0], G[7:0], G[15:0], plus the intermediate group spans.
- Down-sweep, levels k = 3..1: nodes at i = m·2^k + 2^(k−1) − 1 (i ≥ 2^k) combine with i − 2^(k−1).
  - Level 3 fills bit 11.
  - Level 2 fills bits 5, 9, 13.
  - Level 1 fills bits 2, 4, 6, 8, 10, 12, 14.
- Total depth: 7 prefix levels. Maximum fanout of any prefix node: 2.
- Carries: c[0] = cin and c[i+1] = G[i:0].
- Output: sum[i] = p[i] ^ c[i] for i = 0..15; sum[16] = c[16].
- The result register loads on every clock edge regardless of in_valid.
  - out_valid tracks in_valid with the same latency.
  - Bubbles therefore propagate as out_valid = 0 with don't-care sum.

## Timing
- Reset:
  - On a rising edge with rst = 1: sum = 17'h0 and out_valid = 0 on the following cycle.
  - Any operation in flight is discarded; no stale out_valid after reset.
  - rst dominates in_valid on the same edge.
- Default latency is 1 cycle.
  - Inputs are sampled at edge N; the result appears on sum/out_valid after edge N.
  - Throughput is one addition per cycle; back-to-back operands are supported with no stall.
- There is no backpressure; the downstream consumer must accept sum whenever out_valid = 1.
- Inputs are not registered inside the block. The combinational path is from a/b/cin through the 7 prefix levels to the sum register.

## Configuration
- BRENT_KUNG_PIPE_EN
  - Defined: adds a pipeline register after the up-sweep (level 4). It captures the p vector, the up-sweep (G,P) nodes and the bit-0 group term.
    - Latency becomes 2 cycles and throughput stays 1 per cycle.
    - out_valid is delayed through 2 stages.
    - rst clears both stages, including valid bits.
  - Undefined: single-stage design as described above, latency 1.
  - Arithmetic results are identical in both builds.

## Test plan
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, a = 16'hFFFF → sum = 0 and out_valid = 0 throughout; the first valid result appears only after rst deasserts plus the configured latency.
- Basic: a = 902, b = 3932, cin = 0 → sum = 4834 after the configured latency.
- Full carry chain:
  - a = 16'hFFFF, b = 16'h0000, cin = 1 → sum = 17'h10000.
  - a = 16'hFFFF, b = 16'hFFFF, cin = 1 → sum = 17'h1FFFF.
- Back-to-back: stream 3 operand pairs on consecutive cycles: (1,1,0), (16'h8000,16'h8000,0), (16'h00FF,16'h0001,1) → results 2, 17'h10000, 16'h0101 on consecutive cycles, in order, with out_valid = 1 each cycle.
- Random regression: 100 random pairs with each operand < 20000 and cin random, plus a mid-stream rst pulse → every valid sum equals a + b + cin, and out_valid = 0 for the operation in flight at reset.
